trng_markov_extractor: RTL and testbench
========================================

# trng_markov_extractor

Multi-channel, parametrised post-processor for the ring-oscillator TRNG. Each of `NCH` raw entropy channels feeds an order-`ORDER` Markov-aware von Neumann extractor, which removes bias and first-order-`ORDER` correlation. Surviving bits are packed LSB-first into `WIDTH`-bit words and buffered in a `DEPTH`-entry FIFO with a valid/ready output. A raw bypass mode packs unprocessed bits for health testing. This is the successor to the single-channel, single-bit `trng` post-processor; it sits between the oscillator samplers and the bus/health-test logic.

## Interface
Parameters:
- `NCH`, default 4: number of raw entropy channels, at least 1.
- `ORDER`, default 1: Markov context length in bits, 0 to 4. 0 is plain von Neumann.
- `WIDTH`, default 32: output word width. Must satisfy `WIDTH >= NCH`.
- `DEPTH`, default 4: FIFO depth in words, a power of 2, at least 2.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `latch_bit`, in, NCH: raw bits, one per channel.
- `bit_valid`, in, 1: `latch_bit` is sampled on a rising edge only when this is 1.
- `raw_mode`, in, 1: 0 selects extraction, 1 selects bypass (every valid bit is packed).
- `out_valid`, out, 1: FIFO head word is valid.
- `out`, out, WIDTH: FIFO head word.
- `out_ready`, in, 1: consumer accepts the head word.
- `overflow_cnt`, out, 16: count of dropped words, saturating.

## Operation
- **Lane state** (one lane per channel):
  - `hist`: ORDER bits.
  - `warm`: counter 0..ORDER.
  - Per-context `pend[2^ORDER]` and `pend_v[2^ORDER]`.
- **Warm-up.** While `warm < ORDER`, each valid bit only shifts into `hist`, and `warm` increments. No emission.
- **Extraction.** Context `c = hist`, with newest bit in the LSB; c = 0 when ORDER = 0. For a valid bit b:
  - If `pend_v[c]` = 0: set `pend[c]` = b and `pend_v[c]` = 1.
  - Otherwise: clear `pend_v[c]`. If `pend[c]` != b, emit `pend[c]`, so pair 10 gives 1 and pair 01 gives 0. Equal pairs emit nothing.
  - `hist` shifts b in, in every case.
- **Raw mode.** Every valid bit is emitted. Lane state is held.
- **Mode change.** Any cycle where `raw_mode` differs from its registered previous value is a flush cycle:
  - All lane state (`hist`, `warm`, `pend_v`) and the packer accumulator are cleared.
  - That cycle's input is discarded.
  - The FIFO is untouched.
- **Packer.**
  - Emitted bits of one cycle are appended in channel order, channel 0 first, starting at accumulator bit position `cnt`.
  - Accumulator width is WIDTH+NCH.
  - When `cnt + n >= WIDTH`, the low WIDTH bits form a completed word. The remainder shifts down and `cnt` becomes `cnt + n - WIDTH`.
- **FIFO.**
  - A completed word is written when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the word is dropped and `overflow_cnt` increments, saturating at 0xFFFF.
  - A pop occurs when `out_valid` and `out_ready` are both 1.
  - `out` holds its value while `out_valid` = 1 and `out_ready` = 0.

## Timing
- **Reset values:** `out_valid` = 0, `out` = 0, `overflow_cnt` = 0. `cnt`, `warm`, `pend_v` and the FIFO pointers are all 0. The registered mode is 0.
- **Latency:** the word completes on the edge that samples its last contributing bit. `out_valid` is 1 in the following cycle, so latency is 1 cycle.
- **Throughput:** up to NCH bits per cycle in, at most one word per cycle written, one word per cycle popped.
- **Empty FIFO:** write and read in the same cycle give `out_valid` = 1 next cycle. There is no bypass of the registered head.
- **Reset mid-word:** partial accumulator bits are lost. Reset mid-FIFO empties the FIFO.
- **`bit_valid` = 0:** no lane or packer state changes.

## Structure
- `trng_pkg` holds:
  - `CTX_W` function/constant (2^ORDER).
  - Lane-state struct typedef.
  - `OVF_W` = 16.
- The sub-module `markov_vn_lane` is instantiated NCH times. It is per-channel history, pend bank and emit logic, with outputs `emit_v` and `emit_b`.
- Packer and FIFO stay in the top level. The total is roughly 250 lines of RTL.

## Test plan
- **Plain von Neumann pairs.** ORDER=0, NCH=1, WIDTH=8. Input bits 1,0 repeated 8 times, `out_ready` = 1. Expect one word 0xFF, with `out_valid` one cycle after the 16th bit.
- **Order-1 sequence.** ORDER=1, NCH=1. Input stream 1,1,0,1,0. Expect exactly one emitted bit, value 1, from the third bit. Input stream 0,1 alternating for 64 bits: expect zero bits emitted.
- **Raw mode packing.** `raw_mode` = 1 held, NCH=1, WIDTH=8. Input bits 1,0,1,1,0,0,1,0. Expect `out` = 0x4D. Two-channel variant, NCH=2: {ch1,ch0} = 01,01,01,01 gives 0x55.
- **Overflow.** DEPTH=2, `out_ready` = 0, raw mode, 32 bits with WIDTH=8. Expect two words stored and `overflow_cnt` = 2. `out_valid` stays 1 and `out` holds the first word. Full FIFO with a simultaneous pop and push: no drop.
- **Reset and flush.**
  - Reset mid-word: 5 raw bits, then `reset`, then bits 1,1,1,1,1,1,1,1. Expect a single word 0xFF.
  - Mode toggle mid-word: the partial word is discarded, and `warm` restarts the ORDER-bit warm-up.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and constants for the Markov-aware TRNG post-processor.
// Lane state is sized for the largest supported context length (ORDER <= 4)
// so one struct type serves every ORDER; lanes mask off the unused bits.
package trng_pkg;

  localparam int unsigned MAX_ORDER = 4;
  localparam int unsigned MAX_CTX   = 16;
  localparam int unsigned WARM_W    = 3;
  localparam int unsigned OVF_W     = 16;

  // Number of Markov contexts for a given history length.
  function automatic int unsigned ctx_w(input int unsigned order);
    return 32'd1 << order;
  endfunction

  typedef struct packed {
    logic [MAX_CTX-1:0]   pend;
    logic [MAX_CTX-1:0]   pend_v;
    logic [WARM_W-1:0]    warm;
    logic [MAX_ORDER-1:0] hist;
  } lane_state_t;

endpackage

// File: rtl/markov_vn_lane.sv
// One entropy channel: ORDER-bit history, per-context von Neumann pair bank
// and emit decision. Emission is combinational so the packer can consume it
// on the same edge that samples the raw bit.
//   clk, reset     : clock, synchronous active-high reset
//   flush          : clear all lane state, discard this cycle's bit
//   bit_valid      : bit_in is sampled this cycle
//   raw_mode       : pass every valid bit through, hold lane state
//   bit_in         : raw entropy bit
//   emit_v, emit_b : an output bit is produced this cycle, and its value
module markov_vn_lane
  import trng_pkg::*;
#(
  parameter int unsigned ORDER = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic bit_valid,
  input  logic raw_mode,
  input  logic bit_in,
  output logic emit_v,
  output logic emit_b
);

  localparam logic [MAX_ORDER-1:0] HMASK     = MAX_ORDER'(ctx_w(ORDER) - 1);
  localparam logic [WARM_W-1:0]    WARM_FULL = WARM_W'(ORDER);

  lane_state_t              st_q, st_d;
  logic [MAX_ORDER-1:0]     ctx;
  logic [MAX_ORDER-1:0]     hist_shift;

  // Newest bit enters at the LSB; mask keeps only ORDER bits (none for ORDER=0).
  assign ctx        = st_q.hist & HMASK;
  assign hist_shift = ((st_q.hist << 1) | {{(MAX_ORDER-1){1'b0}}, bit_in}) & HMASK;

  // Next lane state and emit decision.
  always_comb begin
    st_d   = st_q;
    emit_v = 1'b0;
    emit_b = 1'b0;
    if (flush) begin
      st_d = '0;
    end else if (bit_valid) begin
      if (raw_mode) begin
        emit_v = 1'b1;
        emit_b = bit_in;
      end else if (st_q.warm != WARM_FULL) begin
        st_d.warm = st_q.warm + WARM_W'(1);
        st_d.hist = hist_shift;
      end else begin
        if (!st_q.pend_v[ctx]) begin
          st_d.pend[ctx]   = bit_in;
          st_d.pend_v[ctx] = 1'b1;
        end else begin
          st_d.pend_v[ctx] = 1'b0;
          // Unequal pair emits its first bit: 10 -> 1, 01 -> 0.
          if (st_q.pend[ctx] != bit_in) begin
            emit_v = 1'b1;
            emit_b = st_q.pend[ctx];
          end
        end
        st_d.hist = hist_shift;
      end
    end
  end

  // Lane state register.
  always_ff @(posedge clk) begin
    if (reset) st_q <= '0;
    else       st_q <= st_d;
  end

endmodule

// File: rtl/trng_markov_extractor.sv
// Multi-channel TRNG post-processor: NCH Markov/von Neumann lanes feed an
// LSB-first word packer and a DEPTH-entry FIFO with valid/ready output.
//   clk, reset   : clock, synchronous active-high reset
//   latch_bit    : raw bits, one per channel, sampled when bit_valid = 1
//   raw_mode     : 1 packs every valid bit unprocessed (health-test bypass)
//   out_valid    : FIFO head is valid
//   out          : FIFO head word
//   out_ready    : consumer accepts the head word
//   overflow_cnt : saturating count of words dropped on a full FIFO
module trng_markov_extractor
  import trng_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned ORDER = 1,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   latch_bit,
  input  logic             bit_valid,
  input  logic             raw_mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  input  logic             out_ready,
  output logic [OVF_W-1:0] overflow_cnt
);

  localparam int unsigned ACC_W  = WIDTH + NCH;
  localparam int unsigned CNT_W  = $clog2(ACC_W + 1);
  localparam int unsigned IDX_W  = $clog2(ACC_W);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  WIDTH_C = CNT_W'(WIDTH);
  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(DEPTH);

  logic              mode_q;
  logic              flush;
  logic [NCH-1:0]    emit_v;
  logic [NCH-1:0]    emit_b;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  pos;
  logic [WIDTH-1:0]  word_c;
  logic              word_done;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [FCNT_W-1:0] widx;
  logic              valid_q;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic              pop, push, full;

  // A mode change restarts extraction from a clean state.
  assign flush = raw_mode ^ mode_q;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    markov_vn_lane #(.ORDER(ORDER)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .bit_valid (bit_valid),
      .raw_mode  (raw_mode),
      .bit_in    (latch_bit[g]),
      .emit_v    (emit_v[g]),
      .emit_b    (emit_b[g])
    );
  end

  // Packer: append this cycle's emitted bits in channel order at cnt.
  // Bits above cnt are kept zero so the shift-down leaves a clean remainder.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    pos       = cnt_q;
    word_c    = '0;
    word_done = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (emit_v[i]) begin
        acc_d[IDX_W'(pos)] = emit_b[i];
        pos                = pos + CNT_W'(1);
      end
    end
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (pos >= WIDTH_C) begin
      word_done = 1'b1;
      word_c    = acc_d[WIDTH-1:0];
      acc_d     = acc_d >> WIDTH;
      cnt_d     = pos - WIDTH_C;
    end else begin
      cnt_d = pos;
    end
  end

  // Shift FIFO: entry 0 is the registered head driving out.
  always_comb begin
    mem_d = mem_q;
    ovf_d = ovf_q;
    pop   = valid_q & out_ready;
    full  = (fcnt_q == DEPTH_C);
    push  = word_done & (~full | pop);
    if (pop) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
    end
    widx = pop ? fcnt_q - FCNT_W'(1) : fcnt_q;
    if (push) mem_d[AW'(widx)] = word_c;
    fcnt_d = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
    if (word_done && !push && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
  end

  // Packer, FIFO and mode registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
      fcnt_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      mode_q  <= raw_mode;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      fcnt_q  <= fcnt_d;
      valid_q <= (fcnt_d != '0);
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid    = valid_q;
  assign out          = mem_q[0];
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_trng_markov_extractor.sv
// Three configurations share stimulus; each is compared every cycle with a
// bit-queue reference model, plus directed checks with fixed expected words.
//   inst 0: NCH=1 ORDER=0 WIDTH=8 DEPTH=4
//   inst 1: NCH=1 ORDER=1 WIDTH=8 DEPTH=2
//   inst 2: NCH=2 ORDER=2 WIDTH=8 DEPTH=4
module tb_trng_markov_extractor;

  localparam int P_NCH [3] = '{1, 1, 2};
  localparam int P_ORD [3] = '{0, 1, 2};
  localparam int P_DEP [3] = '{4, 2, 4};

  logic       clk;
  logic       rst, bv, raw, rdy;
  logic [1:0] lb;
  logic       ov [3];
  logic [7:0] ow [3];
  logic [15:0] oc [3];

  int npass = 0;
  int nchk  = 0;
  int nfail = 0;

  // Reference model state
  bit         m_mode [3];
  int         m_hist [3][2];
  int         m_warm [3][2];
  bit         m_pend [3][2][16];
  bit         m_pv   [3][2][16];
  bit         m_bits [3][$];
  logic [7:0] m_fifo [3][$];
  int         m_ovf  [3];

  bit         ob [40];
  logic [7:0] w0, w1;
  logic [7:0] pat;
  logic [4:0] seq;

  trng_markov_extractor #(.NCH(1), .ORDER(0), .WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .reset(rst), .latch_bit(lb[0:0]), .bit_valid(bv), .raw_mode(raw),
    .out_valid(ov[0]), .out(ow[0]), .out_ready(rdy), .overflow_cnt(oc[0]));
  trng_markov_extractor #(.NCH(1), .ORDER(1), .WIDTH(8), .DEPTH(2)) u_b (
    .clk(clk), .reset(rst), .latch_bit(lb[0:0]), .bit_valid(bv), .raw_mode(raw),
    .out_valid(ov[1]), .out(ow[1]), .out_ready(rdy), .overflow_cnt(oc[1]));
  trng_markov_extractor #(.NCH(2), .ORDER(2), .WIDTH(8), .DEPTH(4)) u_c (
    .clk(clk), .reset(rst), .latch_bit(lb), .bit_valid(bv), .raw_mode(raw),
    .out_valid(ov[2]), .out(ow[2]), .out_ready(rdy), .overflow_cnt(oc[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_lanes(input int k);
    for (int ch = 0; ch < 2; ch++) begin
      m_hist[k][ch] = 0;
      m_warm[k][ch] = 0;
      for (int c = 0; c < 16; c++) m_pv[k][ch][c] = 1'b0;
    end
  endtask

  // One clock edge of the reference for instance k, using the applied inputs.
  task automatic mstep(input int k);
    int         ord, sz, c;
    bit         b, pop, done;
    logic [7:0] w;
    ord  = P_ORD[k];
    done = 1'b0;
    w    = '0;
    if (rst) begin
      m_mode[k] = 1'b0;
      m_bits[k].delete();
      m_fifo[k].delete();
      m_ovf[k] = 0;
      clear_lanes(k);
      return;
    end
    sz  = m_fifo[k].size();
    pop = (sz > 0) && rdy;
    if (raw != m_mode[k]) begin
      m_mode[k] = raw;
      clear_lanes(k);
      m_bits[k].delete();
    end else if (bv) begin
      for (int ch = 0; ch < P_NCH[k]; ch++) begin
        b = lb[ch];
        if (raw) begin
          m_bits[k].push_back(b);
        end else if (m_warm[k][ch] < ord) begin
          m_hist[k][ch] = (m_hist[k][ch] * 2 + int'(b)) % (1 << ord);
          m_warm[k][ch]++;
        end else begin
          c = m_hist[k][ch];
          if (!m_pv[k][ch][c]) begin
            m_pend[k][ch][c] = b;
            m_pv[k][ch][c]   = 1'b1;
          end else begin
            m_pv[k][ch][c] = 1'b0;
            if (m_pend[k][ch][c] != b) m_bits[k].push_back(m_pend[k][ch][c]);
          end
          m_hist[k][ch] = (m_hist[k][ch] * 2 + int'(b)) % (1 << ord);
        end
      end
      if (m_bits[k].size() >= 8) begin
        for (int i = 0; i < 8; i++) w[i] = m_bits[k].pop_front();
        done = 1'b1;
      end
    end
    if (pop) void'(m_fifo[k].pop_front());
    if (done) begin
      if (sz < P_DEP[k] || pop) m_fifo[k].push_back(w);
      else if (m_ovf[k] < 65535) m_ovf[k]++;
    end
  endtask

  task automatic chk_inst(input int k);
    chk($sformatf("valid%0d", k), 32'(ov[k]), 32'(m_fifo[k].size() > 0));
    chk($sformatf("ovf%0d", k), 32'(oc[k]), 32'(m_ovf[k]));
    if (m_fifo[k].size() > 0) chk($sformatf("data%0d", k), 32'(ow[k]), 32'(m_fifo[k][0]));
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 3; k++) mstep(k);
    #1;
    for (int k = 0; k < 3; k++) chk_inst(k);
  endtask

  initial begin
    rst = 1'b1; bv = 1'b0; raw = 1'b0; rdy = 1'b1; lb = '0;
    cyc(); cyc();
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 32'(ov[k]), 32'd0);
      chk("rst_out", 32'(ow[k]), 32'd0);
      chk("rst_ovf", 32'(oc[k]), 32'd0);
    end
    rst = 1'b0;

    // Plain von Neumann: pairs 1,0 x8 give 0xFF on the ORDER=0 lane.
    bv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      lb = ((i % 2) == 0) ? 2'b01 : 2'b00;
      cyc();
      if (i == 14) chk("vn_early_valid", 32'(ov[0]), 32'd0);
    end
    chk("vn_valid", 32'(ov[0]), 32'd1);
    chk("vn_word", 32'(ow[0]), 32'hFF);
    bv = 1'b0;
    cyc();

    // Order-1: alternating 0,1 emits nothing; then 1,1,0,1,0 emits one bit.
    rst = 1'b1; cyc(); rst = 1'b0;
    bv = 1'b1;
    for (int i = 0; i < 64; i++) begin
      lb = ((i % 2) == 0) ? 2'b00 : 2'b01;
      cyc();
    end
    chk("o1_alt_none", 32'(ov[1]), 32'd0);
    rst = 1'b1; cyc(); rst = 1'b0;
    seq = 5'b01011;
    for (int i = 0; i < 5; i++) begin
      lb = {1'b0, seq[i]};
      cyc();
    end
    bv = 1'b0;
    cyc();

    // Raw packing, two channels: {ch1,ch0} = 01 x4 -> 0x55.
    rst = 1'b1; cyc(); rst = 1'b0;
    raw = 1'b1; cyc();
    bv = 1'b1; lb = 2'b01;
    repeat (4) cyc();
    chk("raw2_valid", 32'(ov[2]), 32'd1);
    chk("raw2_word", 32'(ow[2]), 32'h55);

    // Raw packing, one channel: 1,0,1,1,0,0,1,0 -> 0x4D.
    rst = 1'b1; bv = 1'b0; cyc(); rst = 1'b0;
    cyc();
    bv = 1'b1; pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      lb = {1'b0, pat[i]};
      cyc();
    end
    chk("raw1_valid_a", 32'(ov[0]), 32'd1);
    chk("raw1_word_a", 32'(ow[0]), 32'h4D);
    chk("raw1_word_b", 32'(ow[1]), 32'h4D);

    // Overflow on the DEPTH=2 instance, then full FIFO with pop and push.
    rst = 1'b1; bv = 1'b0; cyc(); rst = 1'b0;
    rdy = 1'b0; cyc();
    bv = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ob[i] = 1'($urandom);
      if (i == 39) rdy = 1'b1;
      lb = {1'b0, ob[i]};
      cyc();
      if (i == 31) begin
        for (int j = 0; j < 8; j++) w0[j] = ob[j];
        chk("ovf_valid", 32'(ov[1]), 32'd1);
        chk("ovf_count", 32'(oc[1]), 32'd2);
        chk("ovf_head_held", 32'(ow[1]), 32'(w0));
      end
    end
    for (int j = 0; j < 8; j++) w1[j] = ob[8+j];
    chk("full_popush_count", 32'(oc[1]), 32'd2);
    chk("full_popush_head", 32'(ow[1]), 32'(w1));
    bv = 1'b0;
    repeat (6) cyc();

    // Reset mid-word: partial bits are lost.
    rst = 1'b1; cyc(); rst = 1'b0;
    cyc();
    bv = 1'b1;
    repeat (5) begin lb = 2'($urandom); cyc(); end
    rst = 1'b1; cyc(); rst = 1'b0;
    bv = 1'b0; cyc();
    bv = 1'b1; lb = 2'b11;
    repeat (8) cyc();
    chk("rstmid_word_a", 32'(ow[0]), 32'hFF);
    chk("rstmid_word_b", 32'(ow[1]), 32'hFF);

    // Mode toggle mid-word: partial bits discarded on both flush cycles.
    repeat (5) begin lb = 2'($urandom); cyc(); end
    raw = 1'b0; cyc();
    raw = 1'b1; cyc();
    lb = 2'b11;
    repeat (8) cyc();
    chk("toggle_valid_a", 32'(ov[0]), 32'd1);
    chk("toggle_word_a", 32'(ow[0]), 32'hFF);
    chk("toggle_word_b", 32'(ow[1]), 32'hFF);

    // Randomized traffic: back-pressure heavy first, then mostly ready.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 79) == 0) raw = ~raw;
      bv  = ($urandom_range(0, 3) != 0);
      lb  = 2'($urandom);
      rdy = ($urandom_range(0, 3) < ((n < 1500) ? 1 : 3));
      cyc();
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
